// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game datapath.
//   dir_t   : requested / current movement direction
//   coord_t : packed grid cell {x, y}
//   state_t : collision-checker FSM states (also driven out for debug)
//   opposite(): the direction that would reverse the snake onto itself
package snake_pkg;

  localparam int DEF_GRID_W   = 16;
  localparam int DEF_GRID_H   = 12;
  localparam int DEF_MAX_LEN  = 64;
  localparam int DEF_INIT_LEN = 3;
  localparam int COORD_W      = 4;

  // UP decreases y, DOWN increases y (row 0 is the top of the grid).
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT, ST_DEAD} state_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_body_reg.sv
// Snake body storage: MAX_LEN cells, body[0] is the head.
// Ports:
//   clk, nRst  : clock, asynchronous active-low reset (loads the initial body)
//   shift_en   : push shift_in at body[0], every cell moves one slot back,
//                the last slot falls off
//   shift_in   : new head cell
//   rd_idx     : combinational read address
//   rd_data    : body[rd_idx]
//   head       : body[0]
// Slots at or beyond the current length hold stale cells; the owner of the
// length decides which slots are meaningful.
module snake_body_reg
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int IDX_W    = $clog2(DEF_MAX_LEN)
)(
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 shift_en,
  input  logic [2*COORD_W-1:0] shift_in,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [2*COORD_W-1:0] rd_data,
  output logic [2*COORD_W-1:0] head
);

  coord_t body [MAX_LEN];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      // Initial snake lies horizontally, head in the grid centre, facing right.
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN)
          body[i] <= {COORD_W'(GRID_W / 2 - i), COORD_W'(GRID_H / 2)};
        else
          body[i] <= '0;
      end
    end else if (shift_en) begin
      body[0] <= shift_in;
      for (int i = 1; i < MAX_LEN; i++)
        body[i] <= body[i-1];
    end
  end

  assign rd_data = body[rd_idx];
  assign head    = body[0];

endmodule

// File: rtl/snake_collision_checker.sv
// Snake head/body owner and collision checker, feeding the score tracker.
// Ports:
//   clk, nRst        : clock, asynchronous active-low reset
//   moveTick         : one-cycle step strobe from the game timer
//   dir              : requested direction (dir_t encoding)
//   appleX, appleY   : apple cell, sampled only when a step commits
//   goodColl         : one-cycle pulse, head entered the apple cell
//   badColl          : one-cycle pulse, wall or self hit
//   headX, headY     : current head cell
//   snakeLen         : current length, INIT_LEN..MAX_LEN
//   busy             : a step is being evaluated
//   dead             : a bad collision happened; held until reset
//   state_dbg        : current FSM state (state_t encoding)
// Handshake: moveTick is a strobe accepted only in the idle state (busy=0,
// dead=0); a strobe arriving while busy or dead is dropped, never queued.
module snake_collision_checker
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN
)(
  input  logic       clk,
  input  logic       nRst,
  input  logic       moveTick,
  input  logic [1:0] dir,
  input  logic [3:0] appleX,
  input  logic [3:0] appleY,
  output logic       goodColl,
  output logic       badColl,
  output logic [3:0] headX,
  output logic [3:0] headY,
  output logic [6:0] snakeLen,
  output logic       busy,
  output logic       dead,
  output logic [1:0] state_dbg
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = 7;
  localparam logic signed [5:0] GW = 6'(GRID_W);
  localparam logic signed [5:0] GH = 6'(GRID_H);

  state_t           state;
  dir_t             cur_dir;
  coord_t           next_head;
  logic [IDX_W-1:0] idx;

  coord_t head_c;
  coord_t body_rd;

  dir_t               req_dir;
  dir_t               eff_dir;
  logic signed [5:0]  cand_x;
  logic signed [5:0]  cand_y;
  logic               wall_hit;

  snake_body_reg #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN),
    .IDX_W    (IDX_W)
  ) u_body (
    .clk      (clk),
    .nRst     (nRst),
    .shift_en (state == ST_COMMIT),
    .shift_in (next_head),
    .rd_idx   (idx),
    .rd_data  (body_rd),
    .head     (head_c)
  );

  // Candidate head is computed signed and unwrapped so that stepping off
  // either edge is seen as out of range instead of wrapping to the far side.
  always_comb begin
    req_dir = dir_t'(dir);
    eff_dir = (req_dir == opposite(cur_dir)) ? cur_dir : req_dir;
    cand_x  = $signed({2'b00, head_c.x});
    cand_y  = $signed({2'b00, head_c.y});
    case (eff_dir)
      UP:      cand_y = cand_y - 6'sd1;
      DOWN:    cand_y = cand_y + 6'sd1;
      LEFT:    cand_x = cand_x - 6'sd1;
      default: cand_x = cand_x + 6'sd1;
    endcase
    wall_hit = (cand_x < 6'sd0) || (cand_x >= GW) ||
               (cand_y < 6'sd0) || (cand_y >= GH);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= ST_IDLE;
      cur_dir   <= RIGHT;
      next_head <= '0;
      idx       <= '0;
      snakeLen  <= LEN_W'(INIT_LEN);
      goodColl  <= 1'b0;
      badColl   <= 1'b0;
      busy      <= 1'b0;
      dead      <= 1'b0;
    end else begin
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (moveTick) begin
            cur_dir <= eff_dir;
            if (wall_hit) begin
              badColl <= 1'b1;
              dead    <= 1'b1;
              state   <= ST_DEAD;
            end else begin
              next_head <= {cand_x[COORD_W-1:0], cand_y[COORD_W-1:0]};
              idx       <= '0;
              busy      <= 1'b1;
              state     <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // The tail slot (snakeLen-1) is skipped: it moves away this step.
          if (body_rd == next_head) begin
            badColl <= 1'b1;
            dead    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DEAD;
          end else if (LEN_W'(idx) == snakeLen - LEN_W'(2)) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          // Body shifts this cycle inside u_body. On an apple hit the old
          // tail is kept by growing the length; when full it still drops.
          if (next_head == {appleX, appleY}) begin
            goodColl <= 1'b1;
            if (snakeLen < LEN_W'(MAX_LEN))
              snakeLen <= snakeLen + LEN_W'(1);
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_DEAD;
        end
      endcase
    end
  end

  assign headX     = head_c.x;
  assign headY     = head_c.y;
  assign state_dbg = state;

endmodule
